// File: rtl/f1_start_monitor_pkg.sv
// Shared types and thermometer-code helpers for the F1 start-light monitor.
// Pure declarations; no clocked logic, no flow control.
package f1_pkg;

    localparam int NUM_LIGHTS = 8;
    localparam int LIT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        ARMED,
        TIMING,
        RESULT,
        FAULT
    } monitor_state;

    // A thermometer code has no zero below its top set bit, so adding one carries through cleanly.
    function automatic logic is_thermo(input logic [NUM_LIGHTS-1:0] pattern);
        logic [NUM_LIGHTS-1:0] w_inc;
        w_inc = pattern + NUM_LIGHTS'(1);
        return (pattern & w_inc) == '0;
    endfunction

    function automatic logic [LIT_W-1:0] thermo_count(input logic [NUM_LIGHTS-1:0] pattern);
        logic [LIT_W-1:0] w_cnt;
        w_cnt = '0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            if (pattern[i]) w_cnt = LIT_W'(i + 1);
        end
        return w_cnt;
    endfunction

endpackage

// File: rtl/f1_start_monitor_if.sv
// Lights/button inputs and scoring outputs of the start monitor; master drives, slave monitors.
// Signal bundle only; no latency, no backpressure.
interface f1_start_monitor_if #(parameter int CNT_W = 16);
    import f1_pkg::*;

    logic [NUM_LIGHTS-1:0] lights_in;
    logic                  btn;
    logic                  clr;
    logic [LIT_W-1:0]      lit_count;
    logic                  busy;
    logic                  react_valid;
    logic [CNT_W-1:0]      react_time;
    logic                  jump_start;
    logic                  seq_err;

    modport master (
        output lights_in, btn, clr,
        input  lit_count, busy, react_valid, react_time, jump_start, seq_err
    );

    modport slave (
        input  lights_in, btn, clr,
        output lit_count, busy, react_valid, react_time, jump_start, seq_err
    );

endinterface

// File: rtl/f1_react_counter.sv
// Saturating reaction-time counter with synchronous clear and count enable.
// Count visible one cycle after an enabled edge; never stalls.
module f1_react_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt_inc
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_inc;

    // Holds at all-ones instead of wrapping so a slow driver reads as the maximum time.
    assign w_inc     = (&r_cnt) ? r_cnt : r_cnt + ONE;
    assign o_cnt_inc = w_inc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_inc;
        end
    end

endmodule

// File: rtl/f1_start_monitor.sv
// Checks the start-light thermometer build-up, detects lights-out and times the driver's reaction.
// Outputs registered, one cycle after the sampling edge; no backpressure, every sample is consumed.
module f1_start_monitor
    import f1_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    f1_start_monitor_if.slave    bus
);

    monitor_state     r_state;
    monitor_state     w_next;
    logic             r_btn_q;
    logic [LIT_W-1:0] r_lit_count;
    logic [CNT_W-1:0] r_react_time;
    logic             r_react_valid;
    logic             r_jump_start;
    logic             r_seq_err;

    logic             w_press;
    logic             w_valid;
    logic [LIT_W-1:0] w_cnt;
    logic             w_cnt_clr;
    logic             w_jump;
    logic             w_react;
    logic             w_frozen;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_press  = bus.btn & ~r_btn_q;
    assign w_valid  = is_thermo(bus.lights_in);
    assign w_cnt    = thermo_count(bus.lights_in);
    assign w_frozen = (r_state == RESULT) || (r_state == FAULT);

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_jump    = 1'b0;
        w_react   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_valid)                  w_next = FAULT;
                else if (w_cnt == LIT_W'(1))   w_next = BUILD;
                else if (w_cnt != '0)          w_next = FAULT;
            end
            BUILD: begin
                if (w_press) begin
                    w_next = RESULT;
                    w_jump = 1'b1;
                end else if (!w_valid) begin
                    w_next = FAULT;
                end else if (w_cnt == r_lit_count + LIT_W'(1)) begin
                    if (w_cnt == LIT_W'(NUM_LIGHTS)) w_next = ARMED;
                end else if (w_cnt != r_lit_count) begin
                    w_next = FAULT;
                end
            end
            ARMED: begin
                // A press on the lights-out edge is still before the start, so it is a jump.
                if (w_press) begin
                    w_next = RESULT;
                    w_jump = 1'b1;
                end else if (bus.lights_in == '0) begin
                    w_next    = TIMING;
                    w_cnt_clr = 1'b1;
                end else if (bus.lights_in != '1) begin
                    w_next = FAULT;
                end
            end
            TIMING: begin
                if (w_press) begin
                    w_next  = RESULT;
                    w_react = 1'b1;
                end else if (bus.lights_in != '0) begin
                    w_next = FAULT;
                end
            end
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) r_state <= IDLE;
        else                r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_btn_q       <= 1'b0;
            r_lit_count   <= '0;
            r_react_time  <= '0;
            r_react_valid <= 1'b0;
            r_jump_start  <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_btn_q <= bus.btn;
            if (w_valid && !w_frozen) r_lit_count <= w_cnt;
            if (w_jump)               r_jump_start <= 1'b1;
            // Counter holds N-1 on the N-th edge after lights-out, so latch its incremented value.
            if (w_react) begin
                r_react_valid <= 1'b1;
                r_react_time  <= w_cnt_inc;
            end
            if (w_next == FAULT)      r_seq_err <= 1'b1;
        end
    end

    f1_react_counter #(.CNT_W(CNT_W)) u_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (bus.clr | w_cnt_clr),
        .i_en      (r_state == TIMING),
        .o_cnt_inc (w_cnt_inc)
    );

    assign bus.lit_count   = r_lit_count;
    assign bus.busy        = (r_state == BUILD) || (r_state == ARMED) || (r_state == TIMING);
    assign bus.react_valid = r_react_valid;
    assign bus.react_time  = r_react_time;
    assign bus.jump_start  = r_jump_start;
    assign bus.seq_err     = r_seq_err;

endmodule

// File: tb/tb_f1_start_monitor.sv
// Drives a 16-bit and a 4-bit counter instance in lockstep and scores them against scenario-level expectations.
module tb_f1_start_monitor;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       clr    = 1'b0;
    logic       btn    = 1'b0;
    logic [7:0] lights = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    f1_start_monitor_if #(.CNT_W(16)) if16();
    f1_start_monitor_if #(.CNT_W(4))  if4();

    assign if16.lights_in = lights;
    assign if16.btn       = btn;
    assign if16.clr       = clr;
    assign if4.lights_in  = lights;
    assign if4.btn        = btn;
    assign if4.clr        = clr;

    f1_start_monitor #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(if16));
    f1_start_monitor #(.CNT_W(4))  u_sat (.clk(clk), .rst(rst), .bus(if4));

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // {lit_count, busy, react_valid, jump_start, seq_err, react_time}
    function automatic logic [23:0] obs16();
        return {if16.lit_count, if16.busy, if16.react_valid, if16.jump_start, if16.seq_err, if16.react_time};
    endfunction

    function automatic logic [23:0] obs4();
        return {if4.lit_count, if4.busy, if4.react_valid, if4.jump_start, if4.seq_err, 12'd0, if4.react_time};
    endfunction

    function automatic logic [23:0] pk(input int lc, input logic b, input logic rv, input logic js,
                                       input logic se, input int rt);
        return {4'(lc), b, rv, js, se, 16'(rt)};
    endfunction

    // Reference: reaction time seen by a counter of width w is capped at 2^w-1.
    function automatic int sat(input int n, input int w);
        int cap;
        cap = (1 << w) - 1;
        return (n > cap) ? cap : n;
    endfunction

    function automatic logic thermo_ref(input logic [7:0] p);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i <= 8; i++) if (p == 8'((1 << i) - 1)) hit = 1'b1;
        return hit;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        lights = 8'h00;
        btn    = 1'b0;
        clr    = 1'b1;
        step();
        clr    = 1'b0;
    endtask

    task automatic build_to(input int k, input int hmin, input int hmax);
        for (int i = 1; i <= k; i++) begin
            lights = 8'((1 << i) - 1);
            repeat ($urandom_range(hmax, hmin)) begin
                step();
                checks++;
                if ({if16.lit_count, if16.busy} !== {4'(i), 1'b1}) begin
                    errors++;
                    $display("FAIL build_lit got lit=%0d busy=%0d want lit=%0d busy=1",
                             if16.lit_count, if16.busy, i);
                end
            end
        end
    endtask

    // Lights-out sampled on edge T0, press sampled on edge T0+n.
    task automatic run_reaction(input int n);
        lights = 8'h00;
        btn    = 1'b0;
        step();
        checks++;
        if (if16.busy !== 1'b1) begin
            errors++;
            $display("FAIL timing_busy got %0d want 1", if16.busy);
        end
        for (int c = 1; c < n; c++) step();
        btn = 1'b1;
        step();
        btn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (obs16() !== pk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset16 got %h want %h", obs16(), pk(0, 0, 0, 0, 0, 0));
        end
        checks++;
        if (obs4() !== pk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset4 got %h want %h", obs4(), pk(0, 0, 0, 0, 0, 0));
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_start();
        int n_tab [5];
        n_tab[0] = 25;
        n_tab[1] = 40;
        n_tab[2] = 1;
        n_tab[3] = $urandom_range(60, 2);
        n_tab[4] = $urandom_range(14, 2);
        for (int t = 0; t < 5; t++) begin
            go_idle();
            step();
            step();
            if (t == 0) build_to(8, 3, 3);
            else        build_to(8, 1, 4);
            run_reaction(n_tab[t]);
            checks++;
            if (obs16() !== pk(0, 0, 1, 0, 0, n_tab[t])) begin
                errors++;
                $display("FAIL clean16 n=%0d got %h want %h", n_tab[t], obs16(), pk(0, 0, 1, 0, 0, n_tab[t]));
            end
            checks++;
            if (obs4() !== pk(0, 0, 1, 0, 0, sat(n_tab[t], 4))) begin
                errors++;
                $display("FAIL clean4 n=%0d got %h want %h", n_tab[t], obs4(), pk(0, 0, 1, 0, 0, sat(n_tab[t], 4)));
            end
            repeat (4) begin
                btn = ~btn;
                step();
            end
            checks++;
            if (obs16() !== pk(0, 0, 1, 0, 0, n_tab[t])) begin
                errors++;
                $display("FAIL result_hold got %h want %h", obs16(), pk(0, 0, 1, 0, 0, n_tab[t]));
            end
            go_idle();
            checks++;
            if (obs16() !== pk(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL clr_result got %h want %h", obs16(), pk(0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_jump_start();
        int k_tab [3];
        k_tab[0] = 5;
        k_tab[1] = $urandom_range(8, 1);
        k_tab[2] = $urandom_range(7, 1);
        for (int t = 0; t < 3; t++) begin
            go_idle();
            build_to(k_tab[t], 1, 3);
            btn = 1'b1;
            step();
            checks++;
            if (obs16() !== pk(k_tab[t], 0, 0, 1, 0, 0)) begin
                errors++;
                $display("FAIL jump_k%0d got %h want %h", k_tab[t], obs16(), pk(k_tab[t], 0, 0, 1, 0, 0));
            end
            btn = 1'b0;
            step();
            step();
            checks++;
            if (obs16() !== pk(k_tab[t], 0, 0, 1, 0, 0)) begin
                errors++;
                $display("FAIL jump_hold got %h want %h", obs16(), pk(k_tab[t], 0, 0, 1, 0, 0));
            end
        end
        go_idle();
        build_to(8, 1, 3);
        lights = 8'h00;
        btn    = 1'b1;
        step();
        btn    = 1'b0;
        checks++;
        if (obs16() !== pk(0, 0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL jump_tie got %h want %h", obs16(), pk(0, 0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_faults();
        logic [7:0] bad;
        int         k;
        int         exp_lit;
        for (int f = 0; f < 5; f++) begin
            go_idle();
            case (f)
                0: begin build_to(2, 1, 3); lights = 8'h0F; exp_lit = 4; end
                1: begin lights = 8'h05; exp_lit = 0; end
                2: begin build_to(3, 1, 3); lights = 8'h00; exp_lit = 0; end
                3: begin
                    build_to(8, 1, 2);
                    lights = 8'h00;
                    repeat ($urandom_range(5, 1)) step();
                    lights = 8'h01;
                    exp_lit = 1;
                end
                default: begin
                    k = $urandom_range(7, 1);
                    build_to(k, 1, 2);
                    bad = 8'($urandom_range(255, 0));
                    while (thermo_ref(bad)) bad = 8'($urandom_range(255, 0));
                    lights  = bad;
                    exp_lit = k;
                end
            endcase
            step();
            checks++;
            if (obs16() !== pk(exp_lit, 0, 0, 0, 1, 0)) begin
                errors++;
                $display("FAIL fault%0d got %h want %h", f, obs16(), pk(exp_lit, 0, 0, 0, 1, 0));
            end
            repeat (4) begin
                btn = ~btn;
                step();
            end
            checks++;
            if ({if16.busy, if16.react_valid, if16.jump_start, if16.seq_err} !== 4'b0001) begin
                errors++;
                $display("FAIL fault_hold%0d got %b want 0001", f,
                         {if16.busy, if16.react_valid, if16.jump_start, if16.seq_err});
            end
            go_idle();
            checks++;
            if (obs16() !== pk(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL fault_clr%0d got %h want %h", f, obs16(), pk(0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_held_button();
        go_idle();
        btn = 1'b1;
        step();
        step();
        build_to(8, 1, 3);
        lights = 8'h00;
        step();
        for (int c = 1; c < 10; c++) begin
            if (c == 3) btn = 1'b0;
            step();
        end
        btn = 1'b1;
        step();
        btn = 1'b0;
        checks++;
        if (obs16() !== pk(0, 0, 1, 0, 0, 10)) begin
            errors++;
            $display("FAIL held16 got %h want %h", obs16(), pk(0, 0, 1, 0, 0, 10));
        end
        checks++;
        if (obs4() !== pk(0, 0, 1, 0, 0, 10)) begin
            errors++;
            $display("FAIL held4 got %h want %h", obs4(), pk(0, 0, 1, 0, 0, 10));
        end
    endtask

    task automatic test_reset_clr();
        int n;
        go_idle();
        build_to(8, 1, 2);
        lights = 8'h00;
        step();
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs16() !== pk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rst_timing got %h want %h", obs16(), pk(0, 0, 0, 0, 0, 0));
        end
        lights = 8'h03;
        step();
        checks++;
        if (obs16() !== pk(2, 0, 0, 0, 1, 0)) begin
            errors++;
            $display("FAIL rst_restart got %h want %h", obs16(), pk(2, 0, 0, 0, 1, 0));
        end
        go_idle();
        build_to(4, 1, 2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (obs16() !== pk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL clr_build got %h want %h", obs16(), pk(0, 0, 0, 0, 0, 0));
        end
        step();
        checks++;
        if (obs16() !== pk(4, 0, 0, 0, 1, 0)) begin
            errors++;
            $display("FAIL clr_restart got %h want %h", obs16(), pk(4, 0, 0, 0, 1, 0));
        end
        rst = 1'b1;
        clr = 1'b1;
        step();
        rst = 1'b0;
        clr = 1'b0;
        lights = 8'h00;
        checks++;
        if (obs16() !== pk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rst_clr got %h want %h", obs16(), pk(0, 0, 0, 0, 0, 0));
        end
        n = $urandom_range(30, 2);
        step();
        build_to(8, 1, 1);
        run_reaction(n);
        checks++;
        if (obs4() !== pk(0, 0, 1, 0, 0, sat(n, 4))) begin
            errors++;
            $display("FAIL after_rst4 n=%0d got %h want %h", n, obs4(), pk(0, 0, 1, 0, 0, sat(n, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_clean_start();
        test_jump_start();
        test_faults();
        test_held_button();
        test_reset_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f1_start_monitor.md
Name: f1_start_monitor

Overview:
- Receiver end of the F1 start-light interface: watches the 8-bit lights bus driven by the start-light sequencer.
- Checks that the lights build up correctly, one light at a time, as a thermometer code.
- Detects "lights out" after all 8 lights are lit, then measures driver reaction time in clock cycles up to a button press.
- Flags jump starts and malformed light sequences. Sits between the lights bus / driver button and the display/scoring logic.

Parameters:
- NUM_LIGHTS, 8, width of the lights bus; the spec and tests use 8.
- CNT_W, 16, width of the reaction-time counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- lights_in  in  NUM_LIGHTS  light pattern from the sequencer; bit0 is the first light
- btn  in  1  driver button, level input, synchronous to clk
- clr  in  1  synchronous clear; returns the block to IDLE from any state
- lit_count  out  4  number of lit lights in the last valid sample (0..8)
- busy  out  1  high in BUILD, ARMED, TIMING
- react_valid  out  1  high in RESULT when a legal reaction was measured
- react_time  out  CNT_W  cycles from lights-out to button press
- jump_start  out  1  button pressed before lights out
- seq_err  out  1  illegal light pattern or sequence

Behaviour:
- One clock. Reset is synchronous and active-high, and takes priority over clr. clr takes priority over all FSM transitions.
- All outputs are registered and update one cycle after the sampling edge.
- Reset/clr values: state=IDLE; lit_count=0, react_time=0; busy, react_valid, jump_start, seq_err all 0; btn_q=0.
- Button press: press = btn & ~btn_q. Only rising edges count, so a held button never re-triggers.
- Thermometer check: a pattern is valid iff lights_in & (lights_in+1) == 0. Its count is the position of the top set bit plus 1.
- lit_count loads the count on every valid sample and holds on invalid ones.
- IDLE:
  - count 0: stay.
  - count 1: go to BUILD.
  - any other valid count, or an invalid pattern: go to FAULT.
  - press: ignored.
- BUILD:
  - press: go to RESULT with jump_start=1.
  - else, same count as the previous sample: stay.
  - else, previous count +1: stay, or go to ARMED when the count reaches 8.
  - anything else (skip, decrease, return to 0, invalid pattern): go to FAULT.
- ARMED:
  - press: go to RESULT with jump_start=1. This includes a press in the same cycle that lights go to 0; a tie is a jump start.
  - else, count 8: stay.
  - else, lights 0: go to TIMING with the counter cleared to 0.
  - else: go to FAULT.
- TIMING:
  - The counter increments each cycle and saturates at all-ones (no wrap).
  - press: go to RESULT, react_time = counter value, react_valid=1. Press wins over a simultaneous non-zero lights sample.
  - Timing: lights-0 sampled on edge T0, press sampled on edge T0+N gives react_time=N. N≥1; the minimum measurable reaction is 1.
  - non-zero lights without press: go to FAULT.
- RESULT: outputs hold; the FSM ignores lights and btn and leaves only on clr or rst.
- FAULT: seq_err=1; outputs hold; leaves only on clr or rst.
- busy is decoded from the registered state.
- Reset or clr mid-sequence: the partial sequence is discarded. The next sequence must restart from 1 light.

Decomposition:
- Package f1_pkg holds:
  - typedef enum monitor_state {IDLE, BUILD, ARMED, TIMING, RESULT, FAULT};
  - localparam NUM_LIGHTS=8;
  - function is_thermo(pattern);
  - function thermo_count(pattern).
- Sub-module f1_react_counter: CNT_W saturating up-counter with synchronous clear and count-enable; it is driven by the FSM.
- Everything else lives in f1_start_monitor: state register, next-state logic, edge detect, output registers.

Test Plan:
- Clean start: lights 0→1→3→7→…→FF, each held 3 cycles, then 00; press 25 cycles after lights-out → react_valid=1, react_time=25, busy=0, seq_err=0, jump_start=0.
- Jump start: build to 0x1F, press → RESULT, jump_start=1, react_valid=0. Repeat in ARMED with press on the same edge as lights 00 → jump_start=1.
- Sequence faults, each giving seq_err=1 and staying in FAULT until clr:
  - 0x03→0x0F (skipped light);
  - 0x05 (not a thermometer code);
  - 0x07→0x00 (early lights-out);
  - in TIMING, lights 0x01.
- Held button: btn high from IDLE through the whole sequence, then released and pressed 10 cycles after lights-out → no jump start, react_time=10.
- Saturation with CNT_W=4: press 40 cycles after lights-out → react_time=15, react_valid=1.
- Reset/clr: rst asserted in TIMING → all outputs 0 next cycle, IDLE. clr in RESULT → IDLE with outputs cleared. rst and clr together → reset values.
